bbox_overlay_writer: RTL and testbench

- Writer counterpart to the bounding-box detector: takes a box (xMin, yMin, xMax, yMax) and draws its outline into the same single-port image RAM the detector scans.
- Sits between detector result and frame RAM write port; used to mark detected shapes for display and to generate known-box images for detector regression.
- Writes are strictly raster-ordered (ascending address), so output can stream to RAM or to a hex dump.

---
 rtl/bbox_overlay_writer.sv | 175 +++++++++++++++++
 tb/tb_bbox_overlay_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bbox_overlay_writer.sv
// bbox_overlay_writer: draws the outline of a box into a single-port image RAM. Writes go out
// in strictly ascending address order through a wr_en/wr_ready handshake.
// Optional build macro BBOX_FILL_EN: draw a solid filled box instead of the outline.
module bbox_overlay_writer #(
   parameter int unsigned          IMG_W     = 128,
   parameter int unsigned          IMG_H     = 128,
   parameter int unsigned          COORD_W   = 7,
   parameter int unsigned          ADDR_W    = 14,
   parameter int unsigned          DATA_W    = 8,
   parameter logic [DATA_W-1:0]    BOX_COLOR = 8'hFF
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] xMin,
   input  logic [COORD_W-1:0] yMin,
   input  logic [COORD_W-1:0] xMax,
   input  logic [COORD_W-1:0] yMax,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   input  logic               wr_ready,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [2:0] {StIdle, StTop, StSides, StBottom, StFinish} state_e;

   state_e             state_q, state_d;
   logic [COORD_W-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
   logic [COORD_W-1:0] y_lo_q, y_lo_d, y_hi_q, y_hi_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               wr_en_q, wr_en_d;
   logic               err_q, err_d;

   logic               bad_box;
   logic               fire;
   logic               multi_row;

   // Request checks, handshake and row-count decode used by the next-state logic.
   always_comb begin
      bad_box   = (xMin > xMax) || (yMin > yMax) ||
                  (32'(xMax) >= IMG_W) || (32'(yMax) >= IMG_H);
      fire      = wr_en_q && wr_ready;
      // At least one row strictly between top and bottom.
      multi_row = ({1'b0, y_hi_q}) >= ({1'b0, y_lo_q} + (COORD_W+1)'(2));
   end

   // Next-state: walk the current pixel (x_q, y_q) in raster order, advancing only on transfer.
   always_comb begin
      state_d = state_q;
      x_lo_d  = x_lo_q;
      x_hi_d  = x_hi_q;
      y_lo_d  = y_lo_q;
      y_hi_d  = y_hi_q;
      x_d     = x_q;
      y_d     = y_q;
      wr_en_d = wr_en_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               x_lo_d = xMin;
               x_hi_d = xMax;
               y_lo_d = yMin;
               y_hi_d = yMax;
               if (bad_box) begin
                  err_d   = 1'b1;
                  state_d = StFinish;
               end else begin
                  err_d   = 1'b0;
                  wr_en_d = 1'b1;
                  x_d     = xMin;
                  y_d     = yMin;
                  state_d = StTop;
               end
            end
         end
         StTop: begin
            if (fire) begin
               if (x_q != x_hi_q) begin
                  x_d = x_q + 1'b1;
               end else if (multi_row) begin
                  x_d     = x_lo_q;
                  y_d     = y_lo_q + 1'b1;
                  state_d = StSides;
               end else if (y_hi_q != y_lo_q) begin
                  x_d     = x_lo_q;
                  y_d     = y_hi_q;
                  state_d = StBottom;
               end else begin
                  wr_en_d = 1'b0;
                  state_d = StFinish;
               end
            end
         end
         StSides: begin
            if (fire) begin
`ifdef BBOX_FILL_EN
               if (x_q != x_hi_q) begin
                  x_d = x_q + 1'b1;
               end else
`else
               // Left edge then right edge; a one-column box has only the left edge.
               if ((x_q == x_lo_q) && (x_hi_q != x_lo_q)) begin
                  x_d = x_hi_q;
               end else
`endif
               if (y_q != (y_hi_q - 1'b1)) begin
                  x_d = x_lo_q;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d     = x_lo_q;
                  y_d     = y_hi_q;
                  state_d = StBottom;
               end
            end
         end
         StBottom: begin
            if (fire) begin
               if (x_q != x_hi_q) begin
                  x_d = x_q + 1'b1;
               end else begin
                  wr_en_d = 1'b0;
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            wr_en_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= StIdle;
         x_lo_q  <= '0;
         x_hi_q  <= '0;
         y_lo_q  <= '0;
         y_hi_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         wr_en_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_lo_q  <= x_lo_d;
         x_hi_q  <= x_hi_d;
         y_lo_q  <= y_lo_d;
         y_hi_q  <= y_hi_d;
         x_q     <= x_d;
         y_q     <= y_d;
         wr_en_q <= wr_en_d;
         err_q   <= err_d;
      end
   end

   // Outputs: address/data follow the registered pixel, so they hold during stalls.
   always_comb begin
      wr_en   = wr_en_q;
      wr_addr = ADDR_W'(y_q) * ADDR_W'(IMG_W) + ADDR_W'(x_q);
      wr_data = wr_en_q ? BOX_COLOR : '0;
      busy    = (state_q == StTop) || (state_q == StSides) || (state_q == StBottom);
      done    = (state_q == StFinish);
      err     = err_q;
   end

endmodule

// File: tb/tb_bbox_overlay_writer.sv
// Randomized bench for bbox_overlay_writer; expected write lists come from a raster-scan model.
// Define BBOX_FILL_EN here as well as for the DUT when checking the filled build.
module tb_bbox_overlay_writer;

   localparam int IMG_W = 128;
   localparam int IMG_H = 128;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [6:0] xMin, yMin, xMax, yMax;
   logic       wr_en;
   logic [13:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       busy, done, err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bbox_overlay_writer dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .start    (start),
      .xMin     (xMin),
      .yMin     (yMin),
      .xMax     (xMax),
      .yMax     (yMax),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Expected raster-ordered pixel list for a box.
   function automatic bit on_box(input int x, y, xl, yl, xh, yh);
`ifdef BBOX_FILL_EN
      return 1'b1;
`else
      return (y == yl) || (y == yh) || (x == xl) || (x == xh);
`endif
   endfunction

   task automatic run_box(input int xl, yl, xh, yh, input int ready_pct, input bit inject);
      int  exp_q[$];
      int  got_q[$];
      bit  valid, seen_done, stall, r, err_at_done;
      int  k, done_k, stall_addr, n;
      valid = (xl <= xh) && (yl <= yh) && (xh < IMG_W) && (yh < IMG_H);
      if (valid)
         for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
               if (on_box(x, y, xl, yl, xh, yh)) exp_q.push_back(y * IMG_W + x);
      @(negedge clk);
      start = 1'b1;
      xMin = 7'(xl); yMin = 7'(yl); xMax = 7'(xh); yMax = 7'(yh);
      k = 0; seen_done = 0; stall = 0; done_k = 0; stall_addr = 0; err_at_done = 0;
      while (!seen_done && k < 40000) begin
         @(negedge clk);
         k++;
         start = 1'b0;
         if (inject && k == 3) begin
            start = 1'b1;
            xMin = 7'd0; yMin = 7'd0; xMax = 7'd127; yMax = 7'd127;
         end
         if (k == 1) begin
            check_eq("first_wr_en", wr_en, valid);
            check_eq("busy_after_start", busy, valid);
         end
         if (stall) begin
            check_eq("stall_wr_en", wr_en, 1);
            check_eq("stall_addr", wr_addr, stall_addr);
         end
         if (done) begin
            seen_done   = 1;
            done_k      = k;
            err_at_done = err;
            check_eq("wr_en_at_done", wr_en, 0);
            check_eq("busy_at_done", busy, 0);
         end
         r = ($urandom_range(99) < ready_pct);
         wr_ready = r;
         if (wr_en && r) begin
            got_q.push_back(int'(wr_addr));
            check_eq("wr_data", wr_data, 8'hFF);
         end
         stall      = wr_en && !r;
         stall_addr = int'(wr_addr);
      end
      check_eq("done_seen", seen_done, 1);
      check_eq("err", err_at_done, !valid);
      check_eq("write_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check_eq("wr_addr", got_q[i], exp_q[i]);
      if (ready_pct == 100 && seen_done) check_eq("done_latency", done_k, exp_q.size() + 1);
      @(negedge clk);
      check_eq("done_pulse_width", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("err_held", err, !valid);
   endtask

   initial begin
      int xl, yl, xh, yh;
      reset = 1'b1; start = 1'b0; wr_ready = 1'b1;
      xMin = '0; yMin = '0; xMax = '0; yMax = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      reset = 1'b0;

      run_box(28, 29, 79, 65, 100, 1'b1);
      run_box(5, 5, 5, 5, 100, 1'b0);
      run_box(10, 20, 14, 20, 100, 1'b0);
      run_box(3, 0, 3, 3, 100, 1'b0);
      run_box(40, 10, 39, 20, 100, 1'b0);
      run_box(5, 20, 9, 10, 100, 1'b0);
      run_box(0, 0, 127, 127, 100, 1'b0);
      run_box(28, 34, 69, 78, 50, 1'b1);

      for (int t = 0; t < 10; t++) begin
         xl = $urandom_range(127); yl = $urandom_range(127);
         xh = xl + $urandom_range(30); yh = yl + $urandom_range(30);
         if (xh > 127) xh = 127;
         if (yh > 127) yh = 127;
         if (t % 4 == 3) run_box(xh + 1 > 127 ? 127 : xh + 1, yl, xl, yh, 50, 1'b0);
         else run_box(xl, yl, xh, yh, (t % 2 == 0) ? 50 : 100, 1'b0);
      end

      // Reset in the middle of the side rows.
      @(negedge clk);
      wr_ready = 1'b1;
      start = 1'b1; xMin = 7'd28; yMin = 7'd29; xMax = 7'd79; yMax = 7'd65;
      @(negedge clk);
      start = 1'b0;
      repeat (59) @(negedge clk);
      check_eq("pre_reset_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_wr_en", wr_en, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_done", done, 0);
      @(negedge clk);
      check_eq("mid_rst_done_hold", done, 0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("post_rst_done", done, 0);
      run_box(0, 0, 1, 1, 100, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
